// File: rtl/clk_switch_ctrl_if.sv
// Handshake and heartbeat bundle between the clock-management register
// block (master) and the clock switch sequencer (slave).
interface clk_switch_ctrl_if;
  logic req;
  logic req_sel;
  logic hb_a;
  logic hb_b;
  logic sel;
  logic ack;
  logic err;
  logic busy;
  logic fo_evt;

  modport master (
    output req, req_sel, hb_a, hb_b,
    input  sel, ack, err, busy, fo_evt
  );

  modport slave (
    input  req, req_sel, hb_a, hb_b,
    output sel, ack, err, busy, fo_evt
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Clock switch sequencer running on the always-on reference clock.
// It verifies the requested clock is alive from its heartbeat, drives the
// glitch-free switch select, waits for the switch to settle and then
// acknowledges through a 4-phase req/ack handshake.
// Optional feature macro: CLK_SWITCH_FAILOVER_EN (automatic failover when the
// currently selected clock stops while idle).
module clk_switch_ctrl #(
  parameter int DET_WIN    = 64,
  parameter int MIN_EDGES  = 4,
  parameter int SETTLE_CYC = 8
) (
  input logic              clk,
  input logic              rst,
  clk_switch_ctrl_if.slave bus
);

  localparam int WIN_W  = $clog2(DET_WIN + 1);
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(DET_WIN - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX  = EDGE_W'(MIN_EDGES);
  localparam logic [EDGE_W-1:0] EDGE_NEAR = EDGE_W'(MIN_EDGES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SWITCH,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state;
  logic              tgt;
  logic              fo_run;
  logic [WIN_W-1:0]  win_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [SET_W-1:0]  set_cnt;
  logic              sel_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;

  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic       edge_a;
  logic       edge_b;
  logic       tgt_edge;
  logic       check_pass;

  // Heartbeat synchronizers: two flops for metastability, a third for edge detect.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single flop.
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], bus.hb_a};
      sync_b <= {sync_b[1:0], bus.hb_b};
    end
  end

  // Edge on either heartbeat level, and the pass decision including this cycle's edge.
  always_comb begin
    edge_a     = sync_a[1] ^ sync_a[2];
    edge_b     = sync_b[1] ^ sync_b[2];
    tgt_edge   = tgt ? edge_a : edge_b;
    check_pass = (edge_cnt == EDGE_MAX) || (tgt_edge && (edge_cnt == EDGE_NEAR));
  end

`ifdef CLK_SWITCH_FAILOVER_EN
  logic [WIN_W-1:0]  mon_win;
  logic [EDGE_W-1:0] mon_edges;
  logic              mon_edge;
  logic              mon_trig;
  logic              fo_evt_q;

  // Liveness of the currently selected clock, judged at the end of each idle window.
  always_comb begin
    mon_edge = sel_q ? edge_a : edge_b;
    mon_trig = (state == S_IDLE) && (mon_win == WIN_LAST) &&
               !((mon_edges == EDGE_MAX) || (mon_edge && (mon_edges == EDGE_NEAR)));
  end

  // Free-running idle window; restarts whenever the sequencer leaves IDLE.
  always_ff @(posedge clk) begin
    if (rst || (state != S_IDLE) || (mon_win == WIN_LAST)) begin
      mon_win   <= '0;
      mon_edges <= '0;
    end else begin
      mon_win <= mon_win + WIN_W'(1);
      if (mon_edge && (mon_edges != EDGE_MAX))
        mon_edges <= mon_edges + EDGE_W'(1);
    end
  end

  // One-cycle failover pulse, high exactly during the SWITCH of an internal request.
  always_ff @(posedge clk) begin
    if (rst)
      fo_evt_q <= 1'b0;
    else
      fo_evt_q <= (state == S_CHECK) && (win_cnt == WIN_LAST) && check_pass && fo_run;
  end

  assign bus.fo_evt = fo_evt_q;
`else
  // NOTE: with the monitor compiled out the output is a constant tie-off,
  // not an undriven port.
  assign bus.fo_evt = 1'b0;
`endif

  // Sequencer FSM with registered handshake and select outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tgt      <= 1'b1;
      fo_run   <= 1'b0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      set_cnt  <= '0;
      sel_q    <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            tgt    <= bus.req_sel;
            fo_run <= 1'b0;
            busy_q <= 1'b1;
            if (bus.req_sel == sel_q) begin
              state <= S_DONE;
              ack_q <= 1'b1;
              err_q <= 1'b0;
            end else begin
              state    <= S_CHECK;
              win_cnt  <= '0;
              edge_cnt <= '0;
            end
          end
`ifdef CLK_SWITCH_FAILOVER_EN
          else if (mon_trig) begin
            state    <= S_CHECK;
            tgt      <= ~sel_q;
            fo_run   <= 1'b1;
            busy_q   <= 1'b1;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end
`endif
        end

        S_CHECK: begin
          if (tgt_edge && (edge_cnt != EDGE_MAX))
            edge_cnt <= edge_cnt + EDGE_W'(1);
          if (win_cnt == WIN_LAST) begin
            if (check_pass) begin
              state <= S_SWITCH;
            end else if (fo_run) begin
              state  <= S_IDLE;
              fo_run <= 1'b0;
              busy_q <= 1'b0;
            end else begin
              state <= S_DONE;
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end

        S_SWITCH: begin
          sel_q   <= tgt;
          set_cnt <= '0;
          state   <= S_SETTLE;
        end

        S_SETTLE: begin
          if (set_cnt == SET_LAST) begin
            if (fo_run) begin
              state  <= S_IDLE;
              fo_run <= 1'b0;
              busy_q <= 1'b0;
            end else begin
              state <= S_DONE;
              ack_q <= 1'b1;
              err_q <= 1'b0;
            end
          end else begin
            set_cnt <= set_cnt + SET_W'(1);
          end
        end

        S_DONE: begin
          if (!bus.req) begin
            state  <= S_IDLE;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sel  = sel_q;
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl with default parameters.
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   alive_a = 1'b1;
  bit   alive_b = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  clk_switch_ctrl_if bus ();

  clk_switch_ctrl #(
    .DET_WIN    (64),
    .MIN_EDGES  (4),
    .SETTLE_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Heartbeats toggle every 3 clk cycles while their clock is alive.
  initial begin
    bus.hb_a = 1'b0;
    bus.hb_b = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      if (alive_a) bus.hb_a = ~bus.hb_a;
      if (alive_b) bus.hb_b = ~bus.hb_b;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit req_sel;
    bit alive_a;
    bit alive_b;
    int lat;      // cycles from acceptance to visible ack
    bit err;
    bit sel;      // select after the request completes
    int sel_lat;  // cycle offset where sel changes, 0 if it must not change
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];

  // Drive one request, watch until ack, compare with the scoreboard, then release.
  task automatic do_txn(input vec_t v, input int drop_at, input int toggle_at, input string tag);
    int   t0;
    int   lat;
    int   sel_lat;
    logic sel0;
    bit   fo_seen;
    vec_t e;
    alive_a = v.alive_a;
    alive_b = v.alive_b;
    repeat (10) @(negedge clk);
    sel0        = bus.sel;
    sel_lat     = 0;
    lat         = -1;
    fo_seen     = 1'b0;
    bus.req_sel = v.req_sel;
    bus.req     = 1'b1;
    t0          = cyc;
    sb.push_back(v);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.fo_evt === 1'b1) fo_seen = 1'b1;
      if ((bus.sel !== sel0) && (sel_lat == 0)) sel_lat = cyc - t0;
      if (bus.ack === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      if (cyc - t0 == toggle_at) bus.req_sel = ~bus.req_sel;
      if (cyc - t0 == drop_at) bus.req = 1'b0;
    end
    e = sb.pop_front();
    check($sformatf("%s.ack_latency", tag), lat, e.lat);
    check($sformatf("%s.err", tag), bus.err, e.err);
    check($sformatf("%s.sel", tag), bus.sel, e.sel);
    check($sformatf("%s.sel_latency", tag), sel_lat, e.sel_lat);
    check($sformatf("%s.no_fo_evt", tag), fo_seen, 0);
    if (drop_at < 0) begin
      repeat (3) @(negedge clk);
      check($sformatf("%s.ack_held", tag), bus.ack, 1);
      check($sformatf("%s.err_held", tag), bus.err, e.err);
      bus.req = 1'b0;
    end
    bus.req = 1'b0;
    @(negedge clk);
    check($sformatf("%s.ack_release", tag), bus.ack, 0);
    check($sformatf("%s.err_release", tag), bus.err, 0);
    check($sformatf("%s.busy_release", tag), bus.busy, 0);
  endtask

  initial begin
    int t0;
    bit reached;
    // req_sel, alive_a, alive_b, lat, err, sel, sel_lat
    vecs[0] = '{1'b0, 1'b1, 1'b1, 74, 1'b0, 1'b0, 66};  // switch to clk_b
    vecs[1] = '{1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0,  0};  // no-op, already clk_b
    vecs[2] = '{1'b1, 1'b1, 1'b1, 74, 1'b0, 1'b1, 66};  // switch back to clk_a
    vecs[3] = '{1'b0, 1'b1, 1'b0, 65, 1'b1, 1'b1,  0};  // clk_b dead, refused
    vecs[4] = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1,  0};  // no-op, already clk_a

    rst         = 1'b1;
    bus.req     = 1'b0;
    bus.req_sel = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.sel", bus.sel, 1);
    check("reset.ack", bus.ack, 0);
    check("reset.err", bus.err, 0);
    check("reset.busy", bus.busy, 0);
    check("reset.fo_evt", bus.fo_evt, 0);
    rst = 1'b0;

    foreach (vecs[i]) do_txn(vecs[i], -1, -1, $sformatf("vec%0d", i));

    // Reset asserted for one cycle in the middle of SETTLE.
    alive_a = 1'b1;
    alive_b = 1'b1;
    repeat (10) @(negedge clk);
    bus.req_sel = 1'b0;
    bus.req     = 1'b1;
    t0          = cyc;
    reached     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc - t0 == 70) begin
        reached = 1'b1;
        break;
      end
    end
    check("mid_settle.reached", reached, 1);
    check("mid_settle.sel_switched", bus.sel, 0);
    check("mid_settle.busy", bus.busy, 1);
    rst     = 1'b1;
    bus.req = 1'b0;
    @(negedge clk);
    check("mid_settle.sel_after_rst", bus.sel, 1);
    check("mid_settle.busy_after_rst", bus.busy, 0);
    check("mid_settle.ack_after_rst", bus.ack, 0);
    rst = 1'b0;

    // Request dropped early with req_sel toggled: switch completes, ack for one cycle.
    do_txn('{1'b0, 1'b1, 1'b1, 74, 1'b0, 1'b0, 66}, 10, 5, "early_drop");

`ifdef CLK_SWITCH_FAILOVER_EN
    begin
      int fo_cnt;
      int ack_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      alive_a = 1'b0;
      alive_b = 1'b1;
      fo_cnt  = 0;
      ack_cnt = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (bus.fo_evt === 1'b1) fo_cnt++;
        if (bus.ack !== 1'b0) ack_cnt++;
      end
      check("failover.sel", bus.sel, 0);
      check("failover.fo_pulses", fo_cnt, 1);
      check("failover.ack_cycles", ack_cnt, 0);
      check("failover.busy", bus.busy, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
